// File: rtl/md_pkg.sv
// md_pkg: shared multiply/divide op encodings, FSM states and op classifiers; MDU_MADD_EN enables the MADD/MSUB group
package md_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8,
      MD_MADD  = 4'd9,
      MD_MADDU = 4'd10,
      MD_MSUB  = 4'd11,
      MD_MSUBU = 4'd12
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

`ifdef MDU_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   function automatic logic is_smul(logic [3:0] op);
      return op == MD_MULT || (MADD_EN && op inside {MD_MADD, MD_MSUB});
   endfunction

   function automatic logic is_umul(logic [3:0] op);
      return op == MD_MULTU || (MADD_EN && op inside {MD_MADDU, MD_MSUBU});
   endfunction

   function automatic logic is_div(logic [3:0] op);
      return op inside {MD_DIV, MD_DIVU};
   endfunction

   function automatic logic is_acc(logic [3:0] op);
      return MADD_EN && op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
   endfunction

   function automatic logic is_sub(logic [3:0] op);
      return op inside {MD_MSUB, MD_MSUBU};
   endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit product or {remainder, quotient} for the current md op
module md_calc
   import md_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        wr_o
);

   logic        sgn;
   logic [63:0] sprod, uprod;
   logic [31:0] ua, ub, uq, ur, sq, sr;

   // signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with no special case
   always_comb begin
      sprod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      uprod = {32'd0, a_i} * {32'd0, b_i};
      sgn   = op_i == MD_DIV;
      ua    = (sgn && a_i[31]) ? -a_i : a_i;
      ub    = (b_i == 32'd0) ? 32'd1 : (sgn && b_i[31]) ? -b_i : b_i;
      uq    = ua / ub;
      ur    = ua % ub;
      sq    = (sgn && (a_i[31] ^ b_i[31])) ? -uq : uq;
      sr    = (sgn && a_i[31]) ? -ur : ur;
      res_o = is_smul(op_i) ? sprod : is_umul(op_i) ? uprod : {sr, sq};
      wr_o  = !(is_div(op_i) && b_i == 32'd0);
   end

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO with multi-cycle busy; MDU_MADD_EN adds MADD/MSUB accumulate ops
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op,
   input  logic        md_valid,
   input  logic [31:0] md_a,
   input  logic [31:0] md_b,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rdata
);

   md_state_e   state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [63:0] pend_q, pend_d, res, acc;
   logic        pwr_q, pwr_d, wr;

   md_calc u_calc (
      .op_i  (md_op),
      .a_i   (md_a),
      .b_i   (md_b),
      .res_o (res),
      .wr_o  (wr)
   );

   assign hi = hi_q;
   assign lo = lo_q;

   // next state: result computed and parked at start, committed to HI/LO on the last busy cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      pend_d   = pend_q;
      pwr_d    = pwr_q;
      acc      = {hi_q, lo_q};
      busy     = state_q == ST_RUN;
      start    = md_valid && state_q == ST_IDLE && (is_smul(md_op) || is_umul(md_op) || is_div(md_op));
      md_rdata = (md_op == MD_MFHI) ? hi_q : (md_op == MD_MFLO) ? lo_q : 32'd0;
      if (state_q == ST_IDLE) begin
         if (start) begin
            state_d = ST_RUN;
            cnt_d   = is_div(md_op) ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
            pend_d  = !is_acc(md_op) ? res : is_sub(md_op) ? acc - res : acc + res;
            pwr_d   = wr;
         end else if (md_valid && md_op == MD_MTHI) begin
            hi_d = md_a;
         end else if (md_valid && md_op == MD_MTLO) begin
            lo_d = md_a;
         end
      end else begin
         cnt_d = cnt_q - 8'd1;
         if (cnt_q == 8'd1) begin
            state_d = ST_IDLE;
            if (pwr_q) {hi_d, lo_d} = pend_q;
         end
      end
   end

   // state and architectural registers; async reset discards any in-flight result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         pend_q  <= 64'd0;
         pwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pend_q  <= pend_d;
         pwr_q   <= pwr_d;
      end
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, directly downstream of instruction decode; consumes the decoded multiply/divide operation and forwarded rs/rt operands.
- Owns HI/LO, models multi-cycle mult/div latency and drives the busy signal decode uses to stall every multiply/divide-class instruction.
- MFHI/MFLO read data returns on md_rdata for the EX result mux.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after a MULT/MULTU start.
- DIV_CYCLES, 10, cycles busy is held after a DIV/DIVU start.

Ports:
- clk  input  1  clock; rising edge.
- reset  input  1  asynchronous, active-low reset.
- md_op  input  4  operation code from shared package; MD_NONE when idle.
- md_valid  input  1  md_op is a real, non-bubble EX instruction this cycle.
- md_a  input  32  rs operand, forwarded.
- md_b  input  32  rt operand, forwarded.
- start  output  1  combinational; high when md_valid and md_op is MULT/MULTU/DIV/DIVU and unit idle.
- busy  output  1  registered; high while a computation is outstanding.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.
- md_rdata  output  32  combinational; hi for MFHI, lo for MFLO, else 0.

Behaviour:
- Reset (reset low, any time, async): busy=0, hi=0, lo=0, counter=0, state IDLE; in-flight result discarded.
- States: IDLE, RUN.
- IDLE: start -> RUN, counter loaded with MULT_CYCLES or DIV_CYCLES per op; operands latched and result pair computed into pending_hi/pending_lo.
- RUN: busy=1; counter decrements each cycle; at counter==1 the next edge writes pending to hi/lo, busy=0, state IDLE.
- Result visible on hi/lo exactly N cycles after the start edge; busy high for exactly N cycles, beginning the cycle after start.
- MULT: {hi,lo} = signed 64-bit a*b. MULTU: unsigned 64-bit.
- DIV: lo = signed quotient truncated toward zero, hi = remainder with dividend's sign; 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b==0, DIV/DIVU): full busy timing kept; hi/lo unchanged at completion.
- MTHI/MTLO with md_valid while IDLE: write hi/lo at next edge, single cycle, busy stays 0.
- Any md_op with md_valid while busy: ignored, no state change. Decode must stall all multiply/divide-class instructions while start|busy.
- MFHI/MFLO read the current register value; no bypass of pending results.
- md_valid low: all ops ignored, md_rdata still decodes md_op.

Optional Feature:
- MDU_MADD_EN: when defined, adds MADD/MADDU/MSUB/MSUBU ops, {hi,lo} +/- signed or unsigned 64-bit product, MULT_CYCLES latency, accumulate based on hi/lo sampled at start.
- When not defined, these encodings behave as MD_NONE.

Decomposition:
- Shared package md_pkg: md_op encodings (MD_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, optional MADD group), state localparams.
- Decode's ID_MD detection uses the same constants.
- One sub-module: md_calc, purely combinational 64-bit product/quotient/remainder from op, a and b; md_unit holds FSM, counter and registers.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x2, lo=0xFFFFFFFA.
- DIV a=-7, b=2 -> busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 7/2 -> lo=3, hi=1.
- MTHI 0x1234 then MFHI -> md_rdata=0x1234 next cycle, busy never asserts; DIV b=0 after MTLO 0x55 -> lo stays 0x55, hi stays 0x1234 after 10 cycles.
- MULT started, MTLO 0x99 with md_valid on cycle 2 of busy -> ignored; final lo is the product.
- reset driven low on cycle 3 of DIV -> busy, hi and lo drop to 0 immediately (async); no write at cycle 10.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> after 5 cycles hi=1, lo=0.
